accumulator_drain_arbiter: RTL and testbench
============================================

# accumulator_drain_arbiter

Shares the accumulator memory read port between the MAC-side accumulate read path and a result-drain engine. After the accumulator controller signals completion, the block drains every finished accumulator word in address order into a ready/valid output stream toward the unified buffer. MAC reads always win, and drain reads use only idle read-port cycles. A small output FIFO absorbs downstream backpressure and the 1-cycle memory read latency.

## Interface
Parameters:
- `ADDR_W`, 10: accumulator address width.
- `DATA_W`, MUL_SIZE*32: accumulator word width (one row of lanes).
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, minimum 4.

Ports:
- `clk_i`, in, 1: single clock; everything is rising-edge.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `mac_rd_req_i`, in, 1: MAC-side accumulator read request; highest priority.
- `mac_rd_addr_i`, in, ADDR_W: MAC-side read address.
- `acc_done_i`, in, 1: one-cycle pulse meaning accumulator results are complete.
- `V_dim_i`, in, 8: result height.
- `U_dim_i`, in, 8: result width.
- `acc_rd_en_o`, out, 1: accumulator read enable.
- `acc_rd_addr_o`, out, ADDR_W: accumulator read address.
- `acc_rd_data_i`, in, DATA_W: read data, valid 1 cycle after `acc_rd_en_o`.
- `out_valid_o`, out, 1: output word valid.
- `out_data_o`, out, DATA_W: drained word.
- `out_addr_o`, out, ADDR_W: source address of the drained word.
- `out_ready_i`, in, 1: downstream accept.
- `busy_o`, out, 1: high in any state other than IDLE.
- `drain_done_o`, out, 1: one-cycle pulse when the last word has been accepted.
- `overrun_o`, out, 1: sticky flag; `acc_done_i` arrived while busy.

## Operation
- States: IDLE, DRAIN, FLUSH.
- IDLE:
  - On `acc_done_i`, latch `len = (15'(V_dim_i*U_dim_i)) >> 5`, truncated to ADDR_W bits.
  - Clear the issue address; go to DRAIN.
  - If `len == 0`, go directly to FLUSH instead.
- DRAIN:
  - Issue condition: `!mac_rd_req_i && issued < len && fifo_count + inflight < FIFO_DEPTH`.
  - Each issue drives the read port with the issue address and then increments the address.
  - When `issued == len`, go to FLUSH.
- FLUSH: when the FIFO is empty and nothing is in flight, pulse `drain_done_o` and return to IDLE.
- Read-port mux is combinational:
  - `acc_rd_en_o = mac_rd_req_i | drain_issue`.
  - `acc_rd_addr_o = mac_rd_req_i ? mac_rd_addr_i : issue_addr`.
  - MAC path timing is unchanged by this block.
- A 1-bit in-flight register (plus the registered address) tags drain reads.
  - Return data is pushed to the FIFO only for tagged reads.
  - Data returned for MAC reads is never captured.
- FIFO accounting:
  - Push and pop in the same cycle leaves the count unchanged.
  - Pop occurs on `out_valid_o && out_ready_i`.
  - `out_data_o` and `out_addr_o` are held stable while valid and not ready.
- `acc_done_i` while busy is ignored and sets `overrun_o`, which stays set until reset.
- Reset at any point:
  - State returns to IDLE; FIFO is emptied; in-flight tag and counters are cleared.
  - All outputs take their reset values (below).

## Timing
- Reset values:
  - `acc_rd_en_o=0`, `acc_rd_addr_o=0` (when `mac_rd_req_i=0`).
  - `out_valid_o=0`, `out_data_o=0`, `out_addr_o=0`.
  - `busy_o=0`, `drain_done_o=0`, `overrun_o=0`.
- IDLE to DRAIN takes 1 cycle after `acc_done_i`. The first drain issue can occur in the cycle after the transition.
- Issue at cycle N gives data at N+1, FIFO write at the end of N+1, and `out_valid_o` in cycle N+2.
- Sustained throughput is one word per cycle when `out_ready_i=1` and `mac_rd_req_i=0`.
- `drain_done_o` fires in the cycle after the final pop. For `len=0`, it fires 2 cycles after `acc_done_i`.
- `busy_o` drops in the same cycle as the `drain_done_o` pulse.

## Configuration
- `ACC_DRAIN_STATS_EN`:
  - Defined: adds output `stall_cycles_o` [15:0], a saturating count of DRAIN cycles in which an issue was blocked by `mac_rd_req_i`. The count clears on reset and on each IDLE-to-DRAIN transition.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - `ACC_ADDR_W`, `ACC_DATA_W` (= MUL_SIZE*32);
  - `drain_state_t` enum {IDLE, DRAIN, FLUSH}.
- Sub-module `accumulator_drain_fifo`: synchronous FIFO carrying `{addr, data}`, parameterized by depth and width, exposing count/full/empty. It has no show-ahead bypass, so the 2-cycle latency holds.

## Test plan
- V=32, U=64, `out_ready_i=1`, no MAC traffic, `acc_done_i` pulse:
  - Expect 64 words on consecutive cycles, addresses 0..63, data matching the memory model.
  - Expect `drain_done_o` exactly once.
- Same drain with `mac_rd_req_i` high every other cycle:
  - MAC address always reaches the port; the drain never issues in MAC cycles.
  - Output order is still 0..63; with stats enabled, `stall_cycles_o` equals the number of blocked cycles.
- `out_ready_i` low for 20 cycles mid-drain:
  - At most FIFO_DEPTH words are buffered; no issue while credit is exhausted.
  - Output holds stable; no data is lost or duplicated.
- V=0 with `acc_done_i`: no reads; `drain_done_o` 2 cycles later.
- Second `acc_done_i` during DRAIN: `overrun_o` goes to 1 and the current drain completes unchanged.
- `rst_i` asserted asynchronously mid-drain:
  - All outputs go to reset values immediately.
  - A new `acc_done_i` restarts the drain from address 0.

Source files
------------

// File: rtl/accumulator_drain_arbiter_pkg.sv
// Shared types and sizing for the accumulator drain arbiter.
// Holds address/data widths, the drain FSM state type and the length helper.
// Pure declarations; no logic, no latency, no flow control.
package accumulator_drain_arbiter_pkg;

    localparam int MUL_SIZE   = 4;
    localparam int ACC_ADDR_W = 10;
    localparam int ACC_DATA_W = MUL_SIZE * 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } drain_state_t;

    // Number of accumulator words for a V x U result: product kept to 15 bits,
    // then divided by 32 elements per word.
    function automatic logic [14:0] drain_len(input logic [7:0] v_dim, input logic [7:0] u_dim);
        logic [14:0] prod;
        prod = 15'(v_dim) * 15'(u_dim);
        return prod >> 5;
    endfunction

endpackage

// File: rtl/accumulator_drain_fifo.sv
// Synchronous FIFO holding {addr, data} words for the drain output stream.
// Write-to-read latency 1 cycle (no show-ahead bypass); head visible while not empty.
// Push while full / pop while empty are dropped; the producer uses count as credit.
module accumulator_drain_fifo
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are only observed through the count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/accumulator_drain_arbiter.sv
// Drains finished accumulator words in address order, sharing the read port with the MAC path.
// Latency: drain issue at N -> out_valid_o at N+2; one word per cycle when unblocked.
// Backpressure: FIFO credit (occupancy + in-flight) stalls issue; MAC reads always win. Option: ACC_DRAIN_STATS_EN.
module accumulator_drain_arbiter
    import accumulator_drain_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ACC_ADDR_W,
    parameter int DATA_W     = ACC_DATA_W,
    parameter int FIFO_DEPTH = 4
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mac_rd_req_i,
    input  logic [ADDR_W-1:0] mac_rd_addr_i,
    input  logic              acc_done_i,
    input  logic [7:0]        V_dim_i,
    input  logic [7:0]        U_dim_i,
    output logic              acc_rd_en_o,
    output logic [ADDR_W-1:0] acc_rd_addr_o,
    input  logic [DATA_W-1:0] acc_rd_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              drain_done_o,
`ifdef ACC_DRAIN_STATS_EN
    output logic [15:0]       stall_cycles_o,
`endif
    output logic              overrun_o
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FIFO_W = ADDR_W + DATA_W;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

    drain_state_t      state_q;
    drain_state_t      state_d;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] len_calc;
    logic [ADDR_W-1:0] issue_addr_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_addr_q;
    logic              drain_done_q;
    logic              overrun_q;

    logic              load_len;
    logic              drain_issue;
    logic              done_set;
    logic              words_left;
    logic              credit_ok;
    logic              flush_empty;
    logic [CNT_W:0]    occupancy;

    logic              fifo_pop;
    logic [FIFO_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign len_calc   = ADDR_W'(drain_len(V_dim_i, U_dim_i));
    assign words_left = (issue_addr_q < len_q);

    // Credit counts the word already requested from memory, so a full FIFO never
    // has to accept a late return.
    assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok  = !fifo_full && (occupancy < DEPTH_L);

    // Done once the FIFO is empty after this cycle's pop and nothing remains in flight.
    assign fifo_pop    = out_valid_o && out_ready_i;
    assign flush_empty = !inflight_q && (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop));

    // Drain FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM next state and per-cycle issue/load/done decisions.
    always_comb begin
        state_d     = state_q;
        load_len    = 1'b0;
        drain_issue = 1'b0;
        done_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_done_i) begin
                    load_len = 1'b1;
                    state_d  = (len_calc == '0) ? FLUSH : DRAIN;
                end
            end
            DRAIN: begin
                if (!words_left) begin
                    state_d = FLUSH;
                end else begin
                    drain_issue = !mac_rd_req_i && credit_ok;
                end
            end
            FLUSH: begin
                if (flush_empty) begin
                    done_set = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drain length, issue address and the in-flight tag for the read returning next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q           <= '0;
            issue_addr_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            if (load_len) begin
                len_q        <= len_calc;
                issue_addr_q <= '0;
            end else if (drain_issue) begin
                issue_addr_q <= issue_addr_q + ADDR_W'(1);
            end
            inflight_q <= drain_issue;
            if (drain_issue) begin
                inflight_addr_q <= issue_addr_q;
            end
        end
    end

    // Registered completion pulse (lands with the return to IDLE) and sticky overrun.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drain_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            drain_done_q <= done_set;
            if (acc_done_i && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef ACC_DRAIN_STATS_EN
    logic [15:0] stall_q;
    logic        mac_blocked;

    // A stall is a DRAIN cycle that would have issued had the MAC not owned the port.
    assign mac_blocked = (state_q == DRAIN) && words_left && credit_ok && mac_rd_req_i;

    // Saturating stall counter, restarted at every drain start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && (state_d == DRAIN)) begin
            stall_q <= '0;
        end else if (mac_blocked && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`endif

    accumulator_drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (inflight_q),
        .push_data ({inflight_addr_q, acc_rd_data_i}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Read-port mux stays combinational so MAC timing is untouched.
    assign acc_rd_en_o   = mac_rd_req_i | drain_issue;
    assign acc_rd_addr_o = mac_rd_req_i ? mac_rd_addr_i : issue_addr_q;

    assign out_valid_o  = !fifo_empty;
    assign out_addr_o   = out_valid_o ? fifo_head[FIFO_W-1:DATA_W] : '0;
    assign out_data_o   = out_valid_o ? fifo_head[DATA_W-1:0] : '0;
    assign busy_o       = (state_q != IDLE);
    assign drain_done_o = drain_done_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_accumulator_drain_arbiter.sv
// Scoreboard bench for accumulator_drain_arbiter: randomized MAC traffic and backpressure.
// Expected words come from a memory model and address-order rules; a monitor checks outputs.
// Stimulus and checking run as separate processes sharing the expectation queue.
module tb_accumulator_drain_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 128;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          mac_rd_req_i;
    logic [AW-1:0] mac_rd_addr_i;
    logic          acc_done_i;
    logic [7:0]    V_dim_i;
    logic [7:0]    U_dim_i;
    logic          acc_rd_en_o;
    logic [AW-1:0] acc_rd_addr_o;
    logic [DW-1:0] acc_rd_data_i;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [AW-1:0] out_addr_o;
    logic          out_ready_i;
    logic          busy_o;
    logic          drain_done_o;
    logic          overrun_o;
`ifdef ACC_DRAIN_STATS_EN
    logic [15:0]   stall_cycles_o;
    int            mac_block_cnt = 0;
`endif

    accumulator_drain_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mac_rd_req_i  (mac_rd_req_i),
        .mac_rd_addr_i (mac_rd_addr_i),
        .acc_done_i    (acc_done_i),
        .V_dim_i       (V_dim_i),
        .U_dim_i       (U_dim_i),
        .acc_rd_en_o   (acc_rd_en_o),
        .acc_rd_addr_o (acc_rd_addr_o),
        .acc_rd_data_i (acc_rd_data_i),
        .out_valid_o   (out_valid_o),
        .out_data_o    (out_data_o),
        .out_addr_o    (out_addr_o),
        .out_ready_i   (out_ready_i),
        .busy_o        (busy_o),
        .drain_done_o  (drain_done_o),
`ifdef ACC_DRAIN_STATS_EN
        .stall_cycles_o(stall_cycles_o),
`endif
        .overrun_o     (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents: a distinct pattern per address and per lane.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) begin
            w[i*32 +: 32] = 32'(a) * 32'h9E3779B1 + 32'(i) * 32'h01010101 + 32'h5A5A0000;
        end
        return w;
    endfunction

    // Accumulator memory: one-cycle read latency; garbage when not read.
    always @(posedge clk_i) begin
        acc_rd_data_i <= acc_rd_en_o ? mem_word(acc_rd_addr_o) : ~mem_word(acc_rd_addr_o);
    end

    // Shared scoreboard state.
    ent_t exp_q[$];
    int   exp_len     = 0;
    int   exp_issue   = 0;
    int   outstanding = 0;
    int   pop_cnt     = 0;
    int   first_pop   = 0;
    int   last_pop    = 0;
    int   start_cyc   = 0;
    int   exp_done    = -1;
    int   done_cnt    = 0;
    bit   hold_pending = 0;
    logic [DW-1:0] held_d;
    logic [AW-1:0] held_a;

    int mac_mode = 0;   // 0 none, 1 every other cycle, 2 random
    int rdy_mode = 0;   // 0 always ready, 1 random, 2 held low

    // Background driver for MAC traffic and downstream ready.
    initial begin
        mac_rd_req_i  = 1'b0;
        mac_rd_addr_i = '0;
        out_ready_i   = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (mac_mode)
                1:       mac_rd_req_i = (cyc % 2) == 0;
                2:       mac_rd_req_i = ($urandom % 2) == 0;
                default: mac_rd_req_i = 1'b0;
            endcase
            mac_rd_addr_i = AW'($urandom_range(0, 1023));
            case (rdy_mode)
                1:       out_ready_i = ($urandom % 4) != 0;
                2:       out_ready_i = 1'b0;
                default: out_ready_i = 1'b1;
            endcase
        end
    end

    // Monitor: port arbitration, issue order, credit bound, output order, hold and done timing.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (mac_rd_req_i) begin
                check("mac_rd_en", acc_rd_en_o, 1);
                check("mac_rd_addr", acc_rd_addr_o, mac_rd_addr_i);
            end
            if (hold_pending) begin
                check("hold_valid", out_valid_o, 1);
                check("hold_data", out_data_o, held_d);
                check("hold_addr", out_addr_o, held_a);
            end
            if (out_valid_o && out_ready_i) begin
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    ent_t e;
                    e = exp_q.pop_front();
                    check("out_addr", out_addr_o, e.addr);
                    check("out_data", out_data_o, e.data);
                end
                outstanding--;
                if (pop_cnt == 0) first_pop = cyc;
                last_pop = cyc;
                pop_cnt++;
                if (exp_q.size() == 0) exp_done = cyc + 1;
            end
            if (acc_rd_en_o && !mac_rd_req_i) begin
                check("issue_in_range", exp_issue < exp_len, 1);
                check("issue_addr", acc_rd_addr_o, exp_issue);
                exp_issue++;
                outstanding++;
                check("credit_bound", outstanding <= DEPTH, 1);
            end
`ifdef ACC_DRAIN_STATS_EN
            if (mac_rd_req_i && cyc > start_cyc && exp_issue < exp_len) mac_block_cnt++;
`endif
            hold_pending = out_valid_o && !out_ready_i;
            held_d = out_data_o;
            held_a = out_addr_o;
            if (drain_done_o) begin
                done_cnt++;
                check("done_cycle", cyc, exp_done);
                check("busy_at_done", busy_o, 0);
            end
        end
    end

    // Pulse acc_done; when the block is idle the expected drain goes into the scoreboard.
    task automatic start_drain(input int v, input int u, input bit accept);
        int words;
        @(posedge clk_i);
        #1;
        V_dim_i    = 8'(v);
        U_dim_i    = 8'(u);
        acc_done_i = 1'b1;
        if (accept) begin
            words     = ((v * u) % 32768) / 32 % 1024;
            exp_len   = words;
            exp_issue = 0;
            pop_cnt   = 0;
            start_cyc = cyc;
`ifdef ACC_DRAIN_STATS_EN
            mac_block_cnt = 0;
`endif
            for (int a = 0; a < words; a++) begin
                ent_t e;
                e.addr = AW'(a);
                e.data = mem_word(AW'(a));
                exp_q.push_back(e);
            end
            if (words == 0) exp_done = cyc + 2;
        end
        @(posedge clk_i);
        #1;
        acc_done_i = 1'b0;
    endtask

    // Bounded wait for the completion pulse, then confirm it fired exactly once.
    task automatic wait_done(input string name, input int words);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 3000) begin
            @(posedge clk_i);
            n++;
        end
        repeat (6) @(posedge clk_i);
        check({name, "_done_once"}, done_cnt, start + 1);
        check({name, "_word_count"}, pop_cnt, words);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_out_addr", out_addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_drain_done", drain_done_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_rd_en", acc_rd_en_o, 0);
        check("rst_rd_addr", acc_rd_addr_o, 0);
        exp_q.delete();
        hold_pending = 0;
        outstanding  = 0;
        exp_len      = 0;
        exp_issue    = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i      = 1'b1;
        acc_done_i = 1'b0;
        V_dim_i    = '0;
        U_dim_i    = '0;
        repeat (3) @(posedge clk_i);
        do_reset();
        repeat (2) @(posedge clk_i);

        // Full-rate drain: 64 words back to back.
        start_drain(32, 64, 1);
        wait_done("plain", 64);
        check("plain_first_word_latency", first_pop, start_cyc + 3);
        check("plain_back_to_back", last_pop - first_pop, 63);

        // MAC owns the port every other cycle.
        mac_mode = 1;
        start_drain(32, 64, 1);
        wait_done("mac_alt", 64);
`ifdef ACC_DRAIN_STATS_EN
        check("stall_cycles", stall_cycles_o, mac_block_cnt);
`endif
        mac_mode = 0;

        // Downstream stalls for 20 cycles mid-drain.
        start_drain(32, 64, 1);
        repeat (10) @(posedge clk_i);
        rdy_mode = 2;
        repeat (20) @(posedge clk_i);
        check("stall_fifo_full", outstanding, DEPTH);
        check("stall_valid_held", out_valid_o, 1);
        rdy_mode = 1;
        wait_done("backpressure", 64);
        rdy_mode = 0;

        // Zero-length drain.
        start_drain(0, 50, 1);
        wait_done("empty", 0);

        // Second completion while draining.
        start_drain(32, 64, 1);
        repeat (10) @(posedge clk_i);
        check("busy_mid_drain", busy_o, 1);
        start_drain(1, 1, 0);
        check("overrun_set", overrun_o, 1);
        wait_done("overrun", 64);
        check("overrun_sticky", overrun_o, 1);

        // Random shapes with random MAC traffic and backpressure.
        mac_mode = 2;
        rdy_mode = 1;
        for (int k = 0; k < 4; k++) begin
            int v;
            int u;
            v = $urandom_range(0, 20);
            u = $urandom_range(0, 64);
            start_drain(v, u, 1);
            wait_done("random", (v * u) / 32);
        end
        mac_mode = 0;
        rdy_mode = 0;

        // Asynchronous reset mid-drain, then a fresh drain from address 0.
        start_drain(32, 64, 1);
        repeat (15) @(posedge clk_i);
        do_reset();
        repeat (2) @(posedge clk_i);
        start_drain(8, 16, 1);
        wait_done("after_reset", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
